// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/stall/flush controller for a 5-stage in-order pipeline with a variable-latency data memory.
// Enables and flushes are combinational from state and inputs; state, counters and flags update on the clk rising edge.
// A memory stall freezes every stage. HALT stops all stage loads until reset.
module pipeline_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memToReg_ID_EX,
    input  logic [4:0]  rd_ID_EX,
    input  logic [4:0]  rs1_IF_ID,
    input  logic [4:0]  rs2_IF_ID,
    input  logic        useRs1,
    input  logic        useRs2,
    input  logic        branchTaken_EX,
    input  logic        jump_EX,
    input  logic        memReq_EX_MEM,
    input  logic        memReady,
    input  logic        haltReq,
    output logic        pcWrite,
    output logic        ifidWrite,
    output logic        idexWrite,
    output logic        exmemWrite,
    output logic        memwbWrite,
    output logic        ifidFlush,
    output logic        idexFlush,
    output logic        memwbFlush,
    output logic [15:0] stallCount,
    output logic [15:0] flushCount,
    output logic        halted,
    output logic        memTimeout
);

    // The wait counter is at least 8 bits wide and wide enough to hold MEM_TIMEOUT.
    localparam int WCW = ($clog2(MEM_TIMEOUT + 1) > 8) ? $clog2(MEM_TIMEOUT + 1) : 8;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2
    } state_t;

    state_t           state;
    logic [WCW-1:0]   wait_cnt;
    logic [WCW-1:0]   wait_nxt;
    logic             mem_stall;
    logic             redirect;
    logic             rs1_hit;
    logic             rs2_hit;
    logic             load_use;

    assign mem_stall = memReq_EX_MEM & ~memReady;
    assign redirect  = branchTaken_EX | jump_EX;
    assign rs1_hit   = useRs1 & (rs1_IF_ID == rd_ID_EX);
    assign rs2_hit   = useRs2 & (rs2_IF_ID == rd_ID_EX);
    assign load_use  = memToReg_ID_EX & (rd_ID_EX != 5'd0) & (rs1_hit | rs2_hit);
    assign wait_nxt  = wait_cnt + WCW'(1);

    // haltReq is deliberately absent here: it only acts through the state register.
    always_comb begin
        pcWrite    = 1'b1;
        ifidWrite  = 1'b1;
        idexWrite  = 1'b1;
        exmemWrite = 1'b1;
        memwbWrite = 1'b1;
        ifidFlush  = 1'b0;
        idexFlush  = 1'b0;
        memwbFlush = 1'b0;
        if (!reset) begin
            pcWrite    = 1'b0;
            ifidWrite  = 1'b0;
            idexWrite  = 1'b0;
            exmemWrite = 1'b0;
            memwbWrite = 1'b0;
            ifidFlush  = 1'b1;
            idexFlush  = 1'b1;
            memwbFlush = 1'b1;
        end else if (state == HALT) begin
            pcWrite    = 1'b0;
            ifidWrite  = 1'b0;
            idexWrite  = 1'b0;
            exmemWrite = 1'b0;
            memwbWrite = 1'b0;
        end else if (mem_stall) begin
            pcWrite    = 1'b0;
            ifidWrite  = 1'b0;
            idexWrite  = 1'b0;
            exmemWrite = 1'b0;
            memwbWrite = 1'b0;
            memwbFlush = 1'b1;
        end else if (redirect) begin
            ifidFlush  = 1'b1;
            idexFlush  = 1'b1;
        end else if (load_use) begin
            pcWrite    = 1'b0;
            ifidWrite  = 1'b0;
            idexFlush  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= RUN;
            wait_cnt   <= '0;
            stallCount <= '0;
            flushCount <= '0;
            halted     <= 1'b0;
            memTimeout <= 1'b0;
        end else begin
            if (state != HALT) begin
                if (!pcWrite && stallCount != 16'hFFFF)
                    stallCount <= stallCount + 16'd1;
                if (redirect && !mem_stall && flushCount != 16'hFFFF)
                    flushCount <= flushCount + 16'd1;
            end
            case (state)
                RUN: begin
                    if (mem_stall) begin
                        state    <= MEM_WAIT;
                        wait_cnt <= '0;
                    end else if (haltReq) begin
                        state  <= HALT;
                        halted <= 1'b1;
                    end
                end
                MEM_WAIT: begin
                    if (!mem_stall) begin
                        state <= RUN;
                    end else if (wait_nxt >= WCW'(MEM_TIMEOUT)) begin
                        state      <= HALT;
                        halted     <= 1'b1;
                        memTimeout <= 1'b1;
                    end else begin
                        wait_cnt <= wait_nxt;
                    end
                end
                HALT: begin
                    state <= HALT;
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed scenarios with literal expectations, then randomized traffic against a behavioural model.
module tb_pipeline_hazard_ctrl;
    localparam int TO = 4;

    logic clk = 1'b0;
    logic reset, memToReg_ID_EX, useRs1, useRs2, branchTaken_EX, jump_EX;
    logic memReq_EX_MEM, memReady, haltReq;
    logic [4:0] rd_ID_EX, rs1_IF_ID, rs2_IF_ID;
    logic pcWrite, ifidWrite, idexWrite, exmemWrite, memwbWrite;
    logic ifidFlush, idexFlush, memwbFlush, halted, memTimeout;
    logic [15:0] stallCount, flushCount;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .memToReg_ID_EX(memToReg_ID_EX), .rd_ID_EX(rd_ID_EX),
        .rs1_IF_ID(rs1_IF_ID), .rs2_IF_ID(rs2_IF_ID),
        .useRs1(useRs1), .useRs2(useRs2),
        .branchTaken_EX(branchTaken_EX), .jump_EX(jump_EX),
        .memReq_EX_MEM(memReq_EX_MEM), .memReady(memReady), .haltReq(haltReq),
        .pcWrite(pcWrite), .ifidWrite(ifidWrite), .idexWrite(idexWrite),
        .exmemWrite(exmemWrite), .memwbWrite(memwbWrite),
        .ifidFlush(ifidFlush), .idexFlush(idexFlush), .memwbFlush(memwbFlush),
        .stallCount(stallCount), .flushCount(flushCount),
        .halted(halted), .memTimeout(memTimeout)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model: halted flag, stalled cycles spent waiting on memory (-1 = not waiting), counters.
    bit m_halt, m_to;
    int m_wait;
    int m_stall, m_flush;
    logic [7:0] e_ctl;
    bit e_rdr, e_ms;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] dut_ctl();
        return {pcWrite, ifidWrite, idexWrite, exmemWrite, memwbWrite, ifidFlush, idexFlush, memwbFlush};
    endfunction

    task automatic set_idle();
        reset = 1'b1; memToReg_ID_EX = 0; useRs1 = 0; useRs2 = 0;
        branchTaken_EX = 0; jump_EX = 0; memReq_EX_MEM = 0; memReady = 0; haltReq = 0;
        rd_ID_EX = 0; rs1_IF_ID = 0; rs2_IF_ID = 0;
    endtask

    // Order: pc, ifid, idex, exmem, memwb writes, then ifid, idex, memwb flushes.
    task automatic comb_chk();
        bit lu;
        #2;
        e_ms  = memReq_EX_MEM && !memReady;
        e_rdr = branchTaken_EX || jump_EX;
        lu = memToReg_ID_EX && rd_ID_EX != 0 &&
             ((useRs1 && rs1_IF_ID == rd_ID_EX) || (useRs2 && rs2_IF_ID == rd_ID_EX));
        if (!reset)      e_ctl = 8'b00000_111;
        else if (m_halt) e_ctl = 8'b00000_000;
        else if (e_ms)   e_ctl = 8'b00000_001;
        else if (e_rdr)  e_ctl = 8'b11111_110;
        else if (lu)     e_ctl = 8'b00111_010;
        else             e_ctl = 8'b11111_000;
        chk("ctl", {24'd0, dut_ctl()}, {24'd0, e_ctl});
    endtask

    task automatic edge_chk();
        @(posedge clk);
        if (!reset) begin
            m_halt = 0; m_to = 0; m_wait = -1; m_stall = 0; m_flush = 0;
        end else if (!m_halt) begin
            if (!e_ctl[7] && m_stall < 65535) m_stall++;
            if (e_rdr && !e_ms && m_flush < 65535) m_flush++;
            if (m_wait < 0) begin
                if (e_ms) m_wait = 0;
                else if (haltReq) m_halt = 1;
            end else if (e_ms) begin
                m_wait++;
                if (m_wait >= TO) begin m_halt = 1; m_to = 1; m_wait = -1; end
            end else begin
                m_wait = -1;
            end
        end
        #1;
        chk("stallCount", {16'd0, stallCount}, 32'(m_stall));
        chk("flushCount", {16'd0, flushCount}, 32'(m_flush));
        chk("halted", {31'd0, halted}, {31'd0, m_halt});
        chk("memTimeout", {31'd0, memTimeout}, {31'd0, m_to});
    endtask

    task automatic cycle();
        comb_chk();
        edge_chk();
    endtask

    task automatic do_reset();
        set_idle();
        reset = 1'b0;
        cycle();
        reset = 1'b1;
    endtask

    task automatic set_load_use();
        memToReg_ID_EX = 1; rd_ID_EX = 5; rs1_IF_ID = 5; useRs1 = 1;
    endtask

    initial begin
        m_halt = 0; m_to = 0; m_wait = -1; m_stall = 0; m_flush = 0;
        set_idle();
        reset = 1'b0;
        comb_chk();
        chk("reset_ctl", {24'd0, dut_ctl()}, 32'h07);
        edge_chk();
        chk("reset_halted", {31'd0, halted}, 32'd0);
        chk("reset_stall", {16'd0, stallCount}, 32'd0);
        reset = 1'b1;

        // Load-use: one bubble.
        set_load_use();
        comb_chk();
        chk("lu_ctl", {24'd0, dut_ctl()}, 32'h3A);
        edge_chk();
        set_idle();
        comb_chk();
        chk("lu_after_pc", {31'd0, pcWrite}, 32'd1);
        edge_chk();
        chk("lu_stallCount", {16'd0, stallCount}, 32'd1);

        // Destination x0 never creates a hazard.
        do_reset();
        set_load_use(); rd_ID_EX = 0; rs1_IF_ID = 0;
        comb_chk();
        chk("x0_pc", {31'd0, pcWrite}, 32'd1);
        edge_chk();
        chk("x0_stallCount", {16'd0, stallCount}, 32'd0);

        // Redirect outranks load-use.
        do_reset();
        set_load_use(); branchTaken_EX = 1;
        comb_chk();
        chk("rdr_ctl", {24'd0, dut_ctl()}, 32'hFE);
        edge_chk();
        chk("rdr_flushCount", {16'd0, flushCount}, 32'd1);
        chk("rdr_stallCount", {16'd0, stallCount}, 32'd0);

        // Three-cycle memory wait, then completion.
        do_reset();
        memReq_EX_MEM = 1; memReady = 0;
        for (int i = 0; i < 3; i++) begin
            comb_chk();
            chk("mw_ctl", {24'd0, dut_ctl()}, 32'h01);
            edge_chk();
        end
        memReady = 1;
        comb_chk();
        chk("mw_done_ctl", {24'd0, dut_ctl()}, 32'hF8);
        edge_chk();
        chk("mw_stallCount", {16'd0, stallCount}, 32'd3);
        chk("mw_halted", {31'd0, halted}, 32'd0);

        // Timeout: one RUN stall cycle plus TO stalled cycles in MEM_WAIT.
        do_reset();
        memReq_EX_MEM = 1; memReady = 0;
        for (int i = 0; i < 4; i++) cycle();
        chk("to_not_yet", {31'd0, halted}, 32'd0);
        cycle();
        chk("to_halted", {31'd0, halted}, 32'd1);
        chk("to_flag", {31'd0, memTimeout}, 32'd1);
        chk("to_stallCount", {16'd0, stallCount}, 32'd5);
        comb_chk();
        chk("to_ctl", {24'd0, dut_ctl()}, 32'h00);
        edge_chk();
        do_reset();
        chk("to_rst_halted", {31'd0, halted}, 32'd0);
        chk("to_rst_flag", {31'd0, memTimeout}, 32'd0);
        chk("to_rst_stall", {16'd0, stallCount}, 32'd0);

        // haltReq enters HALT through the state only.
        haltReq = 1;
        comb_chk();
        chk("hr_ctl_same_cycle", {24'd0, dut_ctl()}, 32'hF8);
        edge_chk();
        haltReq = 0;
        chk("hr_halted", {31'd0, halted}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            comb_chk();
            chk("hr_ctl", {24'd0, dut_ctl()}, 32'h00);
            edge_chk();
        end
        chk("hr_still", {31'd0, halted}, 32'd1);

        // Randomized traffic.
        do_reset();
        begin
            int burst = 0;
            for (int n = 0; n < 4000; n++) begin
                memToReg_ID_EX = ($urandom_range(0, 2) == 0);
                rd_ID_EX  = 5'($urandom_range(0, 3));
                rs1_IF_ID = 5'($urandom_range(0, 3));
                rs2_IF_ID = 5'($urandom_range(0, 3));
                useRs1 = $urandom_range(0, 1) == 1;
                useRs2 = $urandom_range(0, 1) == 1;
                branchTaken_EX = ($urandom_range(0, 6) == 0);
                jump_EX = ($urandom_range(0, 9) == 0);
                haltReq = ($urandom_range(0, 40) == 0);
                if (burst == 0 && $urandom_range(0, 30) == 0) burst = $urandom_range(1, 7);
                if (burst > 0) begin
                    memReq_EX_MEM = 1; memReady = 0; burst--;
                end else begin
                    memReq_EX_MEM = $urandom_range(0, 2) == 0;
                    memReady = $urandom_range(0, 1) == 1;
                end
                reset = !(($urandom_range(0, 60) == 0) || (m_halt && $urandom_range(0, 7) == 0));
                cycle();
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end
endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 255: maximum consecutive cycles allowed in MEM_WAIT before entering HALT.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1: synchronous, active-low reset, sampled on the clk rising edge.
REQ-004 SHALL have port memToReg_ID_EX, input, 1: the instruction in EX is a load.
REQ-005 SHALL have port rd_ID_EX, input, 5: destination register of the instruction in EX.
REQ-006 SHALL have ports rs1_IF_ID and rs2_IF_ID, input, 5 each: source registers of the instruction in ID.
REQ-007 SHALL have ports useRs1 and useRs2, input, 1 each: the ID instruction reads rs1 or rs2.
REQ-008 SHALL have ports branchTaken_EX and jump_EX, input, 1 each: control redirect resolved in EX.
REQ-009 SHALL have ports memReq_EX_MEM and memReady, input, 1 each: data memory access in MEM, and memory completion.
REQ-010 SHALL have port haltReq, input, 1: ecall/ebreak decoded in MEM.
REQ-011 SHALL have ports pcWrite, ifidWrite, idexWrite, exmemWrite and memwbWrite, output, 1 each: stage-register load enables.
REQ-012 SHALL have ports ifidFlush, idexFlush and memwbFlush, output, 1 each: insert a bubble (zero control fields) into the register.
REQ-013 SHALL have ports stallCount and flushCount, output, 16 each: saturating event counters.
REQ-014 SHALL have port halted, output, 1: asserted in HALT.
REQ-015 SHALL have port memTimeout, output, 1: sticky flag set on memory timeout.

Function
REQ-016 SHALL implement an FSM with states RUN, MEM_WAIT and HALT; enables and flushes are combinational from the current state and inputs.
REQ-017 SHALL define memStall = memReq_EX_MEM & ~memReady.
REQ-018 SHALL define redirect = branchTaken_EX | jump_EX.
REQ-019 SHALL define loadUse = memToReg_ID_EX & (rd_ID_EX != 0) & ((useRs1 & rs1_IF_ID == rd_ID_EX) | (useRs2 & rs2_IF_ID == rd_ID_EX)).
REQ-020 SHALL apply this priority in RUN and MEM_WAIT: memStall > redirect > loadUse > normal.
REQ-021 SHALL, on memStall: drive all *Write = 0, memwbFlush = 1 and other flushes = 0; the pipeline freezes and a bubble enters WB.
REQ-022 SHALL, on redirect without memStall: drive all *Write = 1, ifidFlush = 1 and idexFlush = 1; this yields a 2-cycle penalty with no further stall.
REQ-023 SHALL, on loadUse without memStall or redirect: drive pcWrite = 0, ifidWrite = 0, idexFlush = 1, and other writes = 1; this yields exactly one bubble.
REQ-024 SHALL, in normal operation: drive all *Write = 1 and all flushes = 0.
REQ-025 SHALL make the following RUN transitions: memStall -> MEM_WAIT; haltReq with no memStall -> HALT; otherwise stay in RUN.
REQ-026 SHALL hold a wait counter (8 bits minimum) in MEM_WAIT: cleared on MEM_WAIT entry, incremented each cycle memStall persists.
REQ-027 SHALL leave MEM_WAIT for RUN on the cycle memStall = 0; that cycle is handled per REQ-022 to REQ-024.
REQ-028 SHALL, when the wait counter reaches MEM_TIMEOUT with memStall still 1, go to HALT and set memTimeout.
REQ-029 SHALL treat HALT as absorbing until reset: all *Write = 0, all flushes = 0, halted = 1.
REQ-030 SHALL increment stallCount by 1 per cycle in which pcWrite = 0 in RUN or MEM_WAIT, saturating at 16'hFFFF.
REQ-031 SHALL increment flushCount by 1 per redirect cycle that is not masked by memStall, saturating at 16'hFFFF.
REQ-032 SHALL have no combinational path from haltReq to the enables; haltReq acts through the state change only.

Reset
REQ-033 SHALL, on a rising edge with reset = 0: set state to RUN, clear the wait counter, stallCount, flushCount and memTimeout; halted = 0 afterwards.
REQ-034 SHALL, while reset = 0, force all *Write = 0 and ifidFlush = idexFlush = memwbFlush = 1, regardless of state.
REQ-035 SHALL honour reset from any state, including mid MEM_WAIT and HALT, with the same result as REQ-033.

Verification
REQ-036 SHALL cover load-use: memToReg_ID_EX=1, rd_ID_EX=5, rs1_IF_ID=5, useRs1=1 for 1 cycle -> pcWrite=0, ifidWrite=0, idexFlush=1 for exactly 1 cycle; stallCount=1.
REQ-037 SHALL cover rd=x0: same as REQ-036 but rd_ID_EX=0 -> no stall; stallCount=0.
REQ-038 SHALL cover redirect vs load-use: branchTaken_EX=1 together with the load-use hazard -> ifidFlush=idexFlush=1, pcWrite=1; flushCount=1, stallCount=0.
REQ-039 SHALL cover memory wait: memReq_EX_MEM=1, memReady=0 for 3 cycles, then memReady=1 -> all writes=0 and memwbFlush=1 for 3 cycles, state back to RUN; stallCount=3.
REQ-040 SHALL cover timeout: MEM_TIMEOUT=4 with memReady held 0 -> HALT after the 4th wait cycle; memTimeout=1, halted=1, writes=0; then reset=0 for one edge -> RUN, counters and flags 0.
REQ-041 SHALL cover halt: haltReq=1 in RUN -> next cycle halted=1 and all writes=0; stays halted while haltReq returns to 0.
